// File: rtl/disp_mode_ctrl.sv
// -----------------------------------------------------------------------------
// disp_mode_ctrl
//
// Display controller sitting in front of the 8-digit scanned seven-segment
// driver. It picks one of three sources (time, date, alarm) for the digit,
// dot and blink inputs of the scanner and runs the front-panel edit state
// machine, which blinks the field being edited and sends increment requests
// to the timekeeping blocks. An idle counter drops back to the time view
// after TIMEOUT_CYC cycles without activity.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   time_bcd     hh:mm:ss, six BCD nibbles, hh in [23:16]
//   date_bcd     yyyymmdd, eight BCD nibbles, yyyy in [31:16]
//   alarm_bcd    alarm hh:mm, hh in [15:8]
//   alarm_en     alarm armed (shown on the rightmost decimal point)
//   btn_mode     single-cycle pulse: cycle the view
//   btn_set      single-cycle pulse: enter / leave edit
//   btn_next     single-cycle pulse: next field in edit
//   btn_inc      single-cycle pulse: increment current field in edit
//   digits       digit7..digit0 codes, digit k in [4k+3:4k]; 10 '-', 11 blank
//   dot          decimal points, active-low, bit k = digit k
//   blink        per-digit blink enable, active-high
//   mode         current target: 0 time, 1 date, 2 alarm
//   edit_active  high while editing
//   inc_pulse    one-cycle increment request
//   inc_target   target of the last increment request
//   inc_field    field of the last increment request
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   V_TIME   | showing time, idle counter held at zero
//   V_DATE   | showing date, idle counter running
//   V_ALARM  | showing alarm time, idle counter running
//   EDIT     | editing field field_q of target target_q, that field blinks
// -----------------------------------------------------------------------------
module disp_mode_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned CNT_W       = 29
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] time_bcd,
    input  logic [31:0] date_bcd,
    input  logic [15:0] alarm_bcd,
    input  logic        alarm_en,
    input  logic        btn_mode,
    input  logic        btn_set,
    input  logic        btn_next,
    input  logic        btn_inc,
    output logic [31:0] digits,
    output logic [7:0]  dot,
    output logic [7:0]  blink,
    output logic [1:0]  mode,
    output logic        edit_active,
    output logic        inc_pulse,
    output logic [1:0]  inc_target,
    output logic [1:0]  inc_field
);

    typedef enum logic [1:0] {
        V_TIME  = 2'd0,
        V_DATE  = 2'd1,
        V_ALARM = 2'd2,
        EDIT    = 2'd3
    } state_t;

    localparam logic [1:0] TGT_TIME  = 2'd0;
    localparam logic [1:0] TGT_DATE  = 2'd1;
    localparam logic [1:0] TGT_ALARM = 2'd2;

    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hB;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    // target_q follows the view outside EDIT, so it doubles as the mode output
    logic [1:0]       target_q;
    logic [1:0]       target_d;
    logic [1:0]       field_q;
    logic [1:0]       field_d;
    logic [CNT_W-1:0] idle_q;
    logic [CNT_W-1:0] idle_d;

    logic             timeout;
    logic             any_btn;
    logic             inc_fire;
    logic [1:0]       last_field;
    state_t           target_view;

    logic [31:0]      digits_d;
    logic [7:0]       dot_d;
    logic [7:0]       blink_d;

    // -------------------------------------------------------------------------
    // Helpers derived from the registered state
    // -------------------------------------------------------------------------
    always_comb begin
        last_field = (target_q == TGT_ALARM) ? 2'd1 : 2'd2;

        target_view = V_TIME;
        case (target_q)
            TGT_DATE:  target_view = V_DATE;
            TGT_ALARM: target_view = V_ALARM;
            default:   target_view = V_TIME;
        endcase
    end

    assign timeout = (idle_q == IDLE_LAST);
    assign any_btn = btn_mode | btn_set | btn_next | btn_inc;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // The if/else chains give btn_set > btn_next > btn_mode > btn_inc: a
    // lower-priority pulse is dropped even when the higher one has no effect
    // in the current state (e.g. btn_next + btn_mode in a view does nothing).
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        field_d  = field_q;
        inc_fire = 1'b0;

        if (timeout) begin
            // Timeout beats any coinciding button, including btn_inc.
            state_d  = V_TIME;
            target_d = TGT_TIME;
            field_d  = 2'd0;
        end else begin
            case (state_q)
                V_TIME, V_DATE, V_ALARM: begin
                    if (btn_set) begin
                        state_d = EDIT;
                        field_d = 2'd0;
                    end else if (btn_next) begin
                        state_d = state_q;
                    end else if (btn_mode) begin
                        case (state_q)
                            V_TIME: begin
                                state_d  = V_DATE;
                                target_d = TGT_DATE;
                            end
                            V_DATE: begin
                                state_d  = V_ALARM;
                                target_d = TGT_ALARM;
                            end
                            default: begin
                                state_d  = V_TIME;
                                target_d = TGT_TIME;
                            end
                        endcase
                    end
                end

                EDIT: begin
                    if (btn_set) begin
                        state_d = target_view;
                        field_d = 2'd0;
                    end else if (btn_next) begin
                        if (field_q == last_field) begin
                            state_d = target_view;
                            field_d = 2'd0;
                        end else begin
                            field_d = field_q + 2'd1;
                        end
                    end else if (btn_mode) begin
                        state_d = state_q;
                    end else if (btn_inc) begin
                        inc_fire = 1'b1;
                    end
                end

                default: begin
                    state_d  = V_TIME;
                    target_d = TGT_TIME;
                    field_d  = 2'd0;
                end
            endcase
        end
    end

    // Any activity, any transition, or simply sitting in the time view
    // restarts the idle count.
    always_comb begin
        if (any_btn || (state_d != state_q) || (state_q == V_TIME)) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDLE_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Display formatting from the registered state and live source data
    // -------------------------------------------------------------------------
    always_comb begin
        digits_d = {8{DIG_BLANK}};
        dot_d    = 8'hFF;
        blink_d  = 8'h00;

        case (target_q)
            TGT_TIME: begin
                digits_d = {time_bcd[23:16], DIG_DASH,
                            time_bcd[15:8],  DIG_DASH,
                            time_bcd[7:0]};
            end
            TGT_DATE: begin
                digits_d = date_bcd;
                // separate yyyy.mm.dd
                dot_d    = 8'hEB;
            end
            TGT_ALARM: begin
                digits_d = {DIG_BLANK, DIG_BLANK,
                            alarm_bcd[15:8], DIG_DASH,
                            alarm_bcd[7:0],  DIG_BLANK};
                dot_d    = {7'h7F, ~alarm_en};
            end
            default: begin
                digits_d = {8{DIG_BLANK}};
            end
        endcase

        if (state_q == EDIT) begin
            case ({target_q, field_q})
                {TGT_TIME,  2'd0}: blink_d = 8'hC0;
                {TGT_TIME,  2'd1}: blink_d = 8'h18;
                {TGT_TIME,  2'd2}: blink_d = 8'h03;
                {TGT_DATE,  2'd0}: blink_d = 8'hF0;
                {TGT_DATE,  2'd1}: blink_d = 8'h0C;
                {TGT_DATE,  2'd2}: blink_d = 8'h03;
                {TGT_ALARM, 2'd0}: blink_d = 8'h30;
                {TGT_ALARM, 2'd1}: blink_d = 8'h06;
                default:           blink_d = 8'h00;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= V_TIME;
            target_q   <= TGT_TIME;
            field_q    <= 2'd0;
            idle_q     <= '0;
            digits     <= {8{DIG_BLANK}};
            dot        <= 8'hFF;
            blink      <= 8'h00;
            inc_pulse  <= 1'b0;
            inc_target <= 2'd0;
            inc_field  <= 2'd0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            field_q    <= field_d;
            idle_q     <= idle_d;
            digits     <= digits_d;
            dot        <= dot_d;
            blink      <= blink_d;
            inc_pulse  <= inc_fire;
            if (inc_fire) begin
                inc_target <= target_q;
                inc_field  <= field_q;
            end
        end
    end

    assign mode        = target_q;
    assign edit_active = (state_q == EDIT);

endmodule

// File: doc/disp_mode_ctrl.md
# disp_mode_ctrl

Display controller in front of the 8-digit scanned seven-segment driver. It selects one of three sources for the digit, dot and blink inputs: time, date or alarm. It also runs an edit state machine driven by the debounced front-panel buttons: it blinks the selected field and issues increment requests to the timekeeping blocks. All display outputs are registered and feed the scanner's `led0..led7`, `dot` and `blink` inputs directly.

## Interface
Parameters:
- `TIMEOUT_CYC`, 500_000_000: idle cycles before auto-return to time view (10 s at 50 MHz).
- `CNT_W`, 29: width of the idle counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `time_bcd`  in  24  hh:mm:ss as six BCD nibbles, hh in [23:16].
- `date_bcd`  in  32  yyyymmdd as eight BCD nibbles, yyyy in [31:16].
- `alarm_bcd`  in  16  alarm hh:mm, hh in [15:8].
- `alarm_en`  in  1  alarm armed.
- `btn_mode`, `btn_set`, `btn_next`, `btn_inc`  in  1 each  single-cycle debounced button pulses.
- `digits`  out  32  digit7..digit0 codes, digit k in [4k+3:4k]; code 10 = '-', code 11 = blank.
- `dot`  out  8  decimal points, active-low, bit k = digit k.
- `blink`  out  8  per-digit blink enable, active-high.
- `mode`  out  2  current target: 0 time, 1 date, 2 alarm.
- `edit_active`  out  1  high while in edit.
- `inc_pulse`  out  1  one-cycle increment request.
- `inc_target`  out  2  target of the increment, same encoding as `mode`.
- `inc_field`  out  2  field index within the target.

## Operation
States: `V_TIME`, `V_DATE`, `V_ALARM`, `EDIT` (with registered target and field).

Button priority when several pulses coincide: `btn_set` > `btn_next` > `btn_mode` > `btn_inc`. Only the highest-priority pulse acts; the others are dropped.

View states:
- `btn_mode` cycles `V_TIME` -> `V_DATE` -> `V_ALARM` -> `V_TIME`.
- `btn_set` enters `EDIT` with target = current view and field 0.
- `btn_next` and `btn_inc` are ignored.

EDIT:
- `btn_inc` raises `inc_pulse` with the current target and field.
- `btn_next` advances the field. On the last field it exits to the view of the target.
- `btn_set` exits to the view of the target immediately.
- `btn_mode` is ignored.
- Field counts: time 3 (hh, mm, ss), date 3 (yyyy, mm, dd), alarm 2 (hh, mm).

Idle counter:
- Cleared on any button pulse, on any state change, and always in `V_TIME`.
- Otherwise increments by 1.
- When it equals TIMEOUT_CYC-1, the next state is `V_TIME`, from any view or from `EDIT`. No inc pulse is emitted on timeout.

Display formats (digit7..digit0; dots all 1 unless stated):
- Time: h h - m m - s s.
- Date: y y y y m m d d, with `dot[4]`=0 and `dot[2]`=0.
- Alarm: blank blank h h - m m blank; `dot[0]` = ~`alarm_en`.

Blink masks: `blink`=0 outside EDIT. In EDIT:
- time: hh 8'hC0, mm 8'h18, ss 8'h03.
- date: yyyy 8'hF0, mm 8'h0C, dd 8'h03.
- alarm: hh 8'h30, mm 8'h06.

The source data is displayed live in EDIT, so increments become visible once the timekeeping block updates.

## Timing
- Reset values: state `V_TIME`, field 0, counter 0, `digits`=32'hBBBBBBBB, `dot`=8'hFF, `blink`=0, `mode`=0, `edit_active`=0, `inc_pulse`=0, `inc_target`=0, `inc_field`=0.
- Reset asserted mid-edit returns to `V_TIME` on the next edge with no inc pulse emitted.
- State and field update on the clock edge that samples the button.
- `mode` and `edit_active` are registered state and change at that same edge.
- `digits`, `dot` and `blink` are registered from the new state and current inputs. They lag the state by 1 cycle, so a button takes effect on them 2 edges after it is sampled.
- Source data changes appear on `digits` 1 cycle later.
- `inc_pulse`, `inc_target` and `inc_field` are registered. The pulse is high for exactly 1 cycle, the cycle after `btn_inc` is sampled. Target and field hold their last values when the pulse is low.
- Back-to-back `btn_inc` pulses give back-to-back `inc_pulse` cycles.

## Test plan
- After reset release, with `time_bcd`=24'h235959 -> `digits`=32'hBBBBBBBB for the first cycle, then 32'h23A59A59, `dot`=8'hFF, `blink`=0.
- Three `btn_mode` pulses -> `mode` steps 1, 2, 0. Date 32'h20240825 shows 32'h20240825 with `dot`=8'hEB. Alarm 16'h0730 with `alarm_en`=1 shows 32'hBB07A30B with `dot`=8'hFE.
- In date view: `btn_set`, then `btn_inc` -> `inc_pulse` for 1 cycle with `inc_target`=1 and `inc_field`=0, `blink`=8'hF0. Then `btn_next` ×3 -> `blink` 8'h0C, then 8'h03, then exit with `edit_active`=0 and `mode`=1.
- `btn_set` and `btn_inc` in the same cycle while in `V_TIME` -> enters EDIT, no `inc_pulse`. `btn_next` and `btn_inc` together in EDIT -> field advances, no `inc_pulse`.
- With TIMEOUT_CYC=16, in `V_ALARM` with no buttons -> `mode`=0 after exactly 16 cycles. A button pulse at cycle 10 restarts the count.
- Reset asserted during alarm edit field 1 -> next cycle `edit_active`=0, `mode`=0, no `inc_pulse`.
